int_div_rem_fu: RTL
===================

// Module: int_div_rem_fu
// PURPOSE
//  Iterative RV32M integer divide/remainder functional unit (DIV, DIVU, REM, REMU).
//  Sits inside the EXE stage as the slave end of the IDRFU start/done handshake.
//  Radix-2 restoring divider: one quotient bit per clock, plus a sign fix-up cycle.
//  EXE stalls its D2E/E2M handshake while the unit is busy.
// PARAMETERS
//  RSZ      32   operand/result width in bits (from cpu_params_pkg)
// PORTS
//  clk_in     in   1     core clock
//  reset_in   in   1     reset: one clock; reset is synchronous and active-low
//  Rs1_data   in   RSZ   dividend
//  Rs2_data   in   RSZ   divisor
//  op         in   IDR_OP_TYPE  DIV, DIVU, REM or REMU
//  start      in   1     request; sampled only in IDLE
//  abort      in   1     pipeline flush: discard any operation in progress
//  quotient   out  RSZ   quotient result
//  remainder  out  RSZ   remainder result
//  done       out  1     1-cycle pulse; results valid in this cycle
// BEHAVIOUR
//  Reset (reset_in==0 at posedge): state=IDLE, done=0, quotient=0, remainder=0, counter=0.
//    Reset takes priority over everything, including an operation in progress.
//  States: IDLE, CALC, FIX, DONE.
//  IDLE, start=1 & abort=0: latch op, sign flags and |Rs1|,|Rs2| (signed ops only; unsigned passes raw).
//    - If divisor==0: next state DONE. Result q=all ones, r=Rs1_data (all 4 ops, raw dividend).
//    - Else if signed op & Rs1==0x8000_0000 & Rs2==all ones: next state DONE. Result q=0x8000_0000, r=0.
//    - Else: next state CALC, counter=RSZ-1, partial remainder (RSZ+1 bits)=0.
//  CALC, each clock:
//    - Shift {prem,dividend} left 1 and trial-subtract the divisor.
//    - If the difference is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
//    - When counter==0: next state FIX; else decrement counter.
//  FIX:
//    - Negate quotient if signed op and sign(Rs1)^sign(Rs2).
//    - Negate remainder if signed op and sign(Rs1)==1.
//    - Register quotient and remainder outputs; next state DONE.
//  DONE: done=1 for exactly this cycle; next state IDLE. Both result outputs are driven for all ops;
//    EXE selects the quotient or remainder by op.
//  Latency, start sampled at edge E0:
//    - Normal: CALC occupies E1..E32 (RSZ edges), FIX->DONE at E33, done high in the cycle after E33.
//      This is 34 cycles start-to-done for RSZ=32.
//    - Special cases (divisor==0, signed overflow): done high in the cycle after E0 (1 cycle).
//  quotient/remainder hold their last values after DONE until the next FIX or special-case load.
//  start while not IDLE: ignored. No queuing; EXE must wait for done.
//  abort in CALC or FIX: next state IDLE, no done pulse, outputs keep their previous values.
//  abort in IDLE: any start in the same cycle is ignored.
//  abort in DONE: done still pulses; EXE is responsible for discarding it.
//  start held high continuously: a new operation begins in the IDLE cycle following DONE.
//  Arithmetic:
//    - Magnitudes are unsigned RSZ bits; |0x8000_0000| = 0x8000_0000, which is valid unsigned.
//    - Trial subtract is RSZ+1 bits wide so the borrow is the sign bit.
//    - Negation is two's complement, truncated to RSZ.
// STRUCTURE
//  cpu_params_pkg:  add IDR_LATENCY = RSZ+2 (used by the EXE stall logic and the bench).
//  cpu_structs_pkg: IDR_OP_TYPE (existing).
//  State enum IDR_STATE_TYPE stays local to the module.
//  Single module, no sub-module; trial-subtract/shift is inline always_comb.
//  EXE connects this module through the IDRFU_intf.slave modport.
// TESTING
//  1. DIV 100/7 -> q=14, r=2, done exactly 34 cycles after start; done width 1 cycle.
//  2. DIV -7/2 -> q=0xFFFF_FFFD (-3), r=0xFFFF_FFFF (-1).
//     REMU 0xFFFF_FFFF/0x10 -> r=0xF, q=0x0FFF_FFFF.
//  3. DIVU 5/0 -> q=0xFFFF_FFFF, r=5, done 1 cycle after start.
//     DIV 0x8000_0000/0xFFFF_FFFF -> q=0x8000_0000, r=0, 1 cycle.
//  4. abort asserted at cycle 10 of a DIV -> no done; next start of 9/3 -> q=3, r=0 after 34 cycles.
//  5. reset_in=0 mid-CALC -> next cycle state IDLE, done=0, outputs 0.
//     start pulsed during CALC is ignored: exactly one done.
//  6. Randomized 10k ops of all 4 types vs reference model, incl. 0, 1, -1, 0x8000_0000, 0x7FFF_FFFF.

Source files
------------

// File: rtl/int_div_rem_fu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_div_rem_fu_pkg
// Description : Shared widths, latency and operation encoding for the
//               iterative RV32M divide/remainder functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
package int_div_rem_fu_pkg;

  // Operand/result width in bits
  localparam int RSZ = 32;

  // Start-to-done latency of a normal (non special-case) operation
  localparam int IDR_LATENCY = RSZ + 2;

  // Width of the iteration counter
  localparam int CNT_W = $clog2(RSZ);

  typedef enum logic [1:0] {
    IDR_DIV  = 2'd0,
    IDR_DIVU = 2'd1,
    IDR_REM  = 2'd2,
    IDR_REMU = 2'd3
  } idr_op_t;

  // DIV and REM treat their operands as two's complement
  function automatic logic is_signed_op(input idr_op_t op);
    return (op == IDR_DIV) || (op == IDR_REM);
  endfunction

endpackage : int_div_rem_fu_pkg
`default_nettype wire

// File: rtl/int_div_rem_fu_if.sv
`default_nettype none
// ============================================================================
// Module      : int_div_rem_fu_if
// Description : Start/done handshake between the EXE stage (master) and the
//               divide/remainder functional unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface int_div_rem_fu_if;
  import int_div_rem_fu_pkg::*;

  logic [RSZ-1:0] Rs1_data;
  logic [RSZ-1:0] Rs2_data;
  idr_op_t        op;
  logic           start;
  logic           abort;
  logic [RSZ-1:0] quotient;
  logic [RSZ-1:0] remainder;
  logic           done;

  modport master (
    output Rs1_data, Rs2_data, op, start, abort,
    input  quotient, remainder, done
  );

  modport slave (
    input  Rs1_data, Rs2_data, op, start, abort,
    output quotient, remainder, done
  );

endinterface : int_div_rem_fu_if
`default_nettype wire

// File: rtl/int_div_rem_fu.sv
`default_nettype none
// ============================================================================
// Module      : int_div_rem_fu
// Description : Radix-2 restoring divider for DIV/DIVU/REM/REMU. One quotient
//               bit per clock on operand magnitudes, followed by a sign
//               fix-up cycle. Divide-by-zero and signed overflow complete in
//               a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module int_div_rem_fu
  import int_div_rem_fu_pkg::*;
(
  input  wire logic       clk_in,
  input  wire logic       reset_in,
  int_div_rem_fu_if.slave idr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [RSZ-1:0] INT_MIN = {1'b1, {(RSZ-1){1'b0}}};

  logic [1:0]     r_state;
  logic [1:0]     w_next_state;
  logic [CNT_W-1:0] r_cnt;

  // Partial remainder is always below the divisor, so RSZ bits hold it;
  // only the trial subtraction needs the extra borrow bit.
  logic [RSZ-1:0] r_prem;
  logic [RSZ-1:0] r_dvd;      // dividend magnitude, becomes quotient magnitude
  logic [RSZ-1:0] r_dvs;      // divisor magnitude
  logic           r_neg_q;
  logic           r_neg_r;
  logic [RSZ-1:0] r_quotient;
  logic [RSZ-1:0] r_remainder;

  logic           w_accept;
  logic           w_signed;
  logic           w_rs1_neg;
  logic           w_rs2_neg;
  logic [RSZ-1:0] w_abs1;
  logic [RSZ-1:0] w_abs2;
  logic           w_div_zero;
  logic           w_ovf;
  logic [RSZ:0]   w_shift;
  logic [RSZ:0]   w_diff;
  logic           w_q_bit;
  logic [RSZ-1:0] w_q_fix;
  logic [RSZ-1:0] w_r_fix;

  // Operand decode at acceptance: signs, magnitudes and special cases
  always_comb begin
    w_accept   = (r_state == S_IDLE) && idr.start && !idr.abort;
    w_signed   = is_signed_op(idr.op);
    w_rs1_neg  = w_signed && idr.Rs1_data[RSZ-1];
    w_rs2_neg  = w_signed && idr.Rs2_data[RSZ-1];
    // |INT_MIN| wraps back to INT_MIN, which is the correct unsigned magnitude
    w_abs1     = w_rs1_neg ? (~idr.Rs1_data + 1'b1) : idr.Rs1_data;
    w_abs2     = w_rs2_neg ? (~idr.Rs2_data + 1'b1) : idr.Rs2_data;
    w_div_zero = (idr.Rs2_data == '0);
    w_ovf      = w_signed && (idr.Rs1_data == INT_MIN) && (idr.Rs2_data == '1);
  end

  // One restoring step: shift in the next dividend bit and trial-subtract
  always_comb begin
    w_shift = {r_prem, r_dvd[RSZ-1]};
    w_diff  = w_shift - {1'b0, r_dvs};
    w_q_bit = ~w_diff[RSZ];
  end

  // Sign correction of the unsigned results
  always_comb begin
    w_q_fix = r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
    w_r_fix = r_neg_r ? (~r_prem + 1'b1) : r_prem;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = (w_div_zero || w_ovf) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (idr.abort) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == '0) begin
          w_next_state = S_FIX;
        end
      end
      S_FIX: begin
        w_next_state = idr.abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: operand capture, iteration, fix-up and result registers
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_cnt       <= '0;
      r_prem      <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_neg_q <= w_rs1_neg ^ w_rs2_neg;
            r_neg_r <= w_rs1_neg;
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= idr.Rs1_data;
            end else if (w_ovf) begin
              r_quotient  <= INT_MIN;
              r_remainder <= '0;
            end else begin
              r_cnt  <= CNT_W'(RSZ - 1);
              r_prem <= '0;
              r_dvd  <= w_abs1;
              r_dvs  <= w_abs2;
            end
          end
        end
        S_CALC: begin
          if (!idr.abort) begin
            r_prem <= w_q_bit ? w_diff[RSZ-1:0] : w_shift[RSZ-1:0];
            r_dvd  <= {r_dvd[RSZ-2:0], w_q_bit};
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_FIX: begin
          if (!idr.abort) begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign idr.quotient  = r_quotient;
  assign idr.remainder = r_remainder;
  assign idr.done      = (r_state == S_DONE);

endmodule : int_div_rem_fu
`default_nettype wire
